// File: rtl/run_length_expander_pkg.sv
// Shared types and helpers for the run-length expander.
// Optional feature macro: RUN_LENGTH_EXPANDER_BITCOUNT_EN (see top module).
package runLengthPkg;

    // Expander control states: IDLE accepts a token, RUN expands it.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a bit count that can hold every value 0..width.
    function automatic int fillWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/run_length_expander_if.sv
// Token and word stream bundle for the run-length expander.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// The producer holds valid and its payload steady until that edge; valid
// never depends combinationally on ready; ready may be driven freely.
// master = token producer / word consumer; slave = the expander.
interface run_length_expander_if #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 8
);
    localparam int FW = runLengthPkg::fillWidth(WIDTH);

    logic                 tokValid;
    logic                 tokReady;
    logic                 tokBit;
    logic [LEN_WIDTH-1:0] tokLength;
    logic                 tokLast;

    logic                 wordValid;
    logic                 wordReady;
    logic [WIDTH-1:0]     word;
    logic [FW-1:0]        wordFill;
    logic                 wordLast;

    modport master (
        output tokValid, tokBit, tokLength, tokLast, wordReady,
        input  tokReady, wordValid, word, wordFill, wordLast
    );

    modport slave (
        input  tokValid, tokBit, tokLength, tokLast, wordReady,
        output tokReady, wordValid, word, wordFill, wordLast
    );
endinterface

// File: rtl/run_length_expander_thermometer_mask.sv
// Thermometer mask: count ones starting at bit WIDTH-1-offset, going downward.
// Bits past the LSB are simply dropped.
module thermometerMask #(
    parameter int WIDTH = 32,
    parameter int OW    = 6,
    parameter int CW    = 15
) (
    input  logic [OW-1:0]    offset,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] mask
);

    // Bit i sits at stream position WIDTH-1-i; set it when inside [offset, offset+count).
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((CW'(WIDTH - 1 - i) >= CW'(offset)) &&
                (CW'(WIDTH - 1 - i) < (CW'(offset) + count))) begin
                mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_length_expander.sv
// Run-length expander: turns (bit, length, last) tokens into packed MSB-first
// words. Optional macro RUN_LENGTH_EXPANDER_BITCOUNT_EN adds a running total
// of wordFill over all words taken by the consumer (bitCount, wraps at 2^32).
module run_length_expander
    import runLengthPkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    run_length_expander_if.slave bus,
`ifdef RUN_LENGTH_EXPANDER_BITCOUNT_EN
    output logic [31:0]          bitCount,
`endif
    output state_t               dbgState
);

    localparam int FW = fillWidth(WIDTH);
    // Wide enough for remaining, free space and fill+n without truncation.
    localparam int CW = LEN_WIDTH + FW + 1;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 bit_q, bit_d;
    logic                 last_q, last_d;
    logic [WIDTH-1:0]     word_q, word_d;
    logic [FW-1:0]        wfill_q, wfill_d;
    logic                 wlast_q, wlast_d;
    logic                 wvalid_q, wvalid_d;
    logic                 tok_ready;

    logic [CW-1:0]        rem_ext, space, n, fill_sum;
    logic                 run_ends, complete, stall;
    logic [WIDTH-1:0]     mask, acc_next;

    assign rem_ext  = CW'(rem_q);
    assign space    = CW'(WIDTH) - CW'(fill_q);
    assign n        = (rem_ext < space) ? rem_ext : space;
    assign fill_sum = CW'(fill_q) + n;
    assign run_ends = (rem_ext == n);
    assign complete = (fill_sum == CW'(WIDTH)) || (run_ends && last_q);
    // A completed word needs a free output slot; otherwise the cycle is frozen.
    assign stall    = complete && wvalid_q && !bus.wordReady;

    thermometerMask #(
        .WIDTH (WIDTH),
        .OW    (FW),
        .CW    (CW)
    ) u_mask (
        .offset (fill_q),
        .count  (n),
        .mask   (mask)
    );

    // A zero run leaves the accumulator alone; unfilled bits stay zero.
    assign acc_next = bit_q ? (acc_q | mask) : acc_q;

    // Next-state and handshake logic for the IDLE/RUN controller.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        rem_d     = rem_q;
        bit_d     = bit_q;
        last_d    = last_q;
        word_d    = word_q;
        wfill_d   = wfill_q;
        wlast_d   = wlast_q;
        wvalid_d  = wvalid_q && !bus.wordReady;
        tok_ready = 1'b0;
        case (state_q)
            IDLE: begin
                tok_ready = 1'b1;
                if (bus.tokValid) begin
                    bit_d   = bus.tokBit;
                    rem_d   = bus.tokLength;
                    last_d  = bus.tokLast;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    rem_d = LEN_WIDTH'(rem_ext - n);
                    if (run_ends) begin
                        state_d = IDLE;
                    end
                    if (complete) begin
                        word_d   = acc_next;
                        wfill_d  = FW'(fill_sum);
                        wlast_d  = last_q && run_ends;
                        wvalid_d = 1'b1;
                        acc_d    = '0;
                        fill_d   = '0;
                    end else begin
                        acc_d  = acc_next;
                        fill_d = FW'(fill_sum);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial word and run.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            fill_q   <= '0;
            rem_q    <= '0;
            bit_q    <= 1'b0;
            last_q   <= 1'b0;
            word_q   <= '0;
            wfill_q  <= '0;
            wlast_q  <= 1'b0;
            wvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            fill_q   <= fill_d;
            rem_q    <= rem_d;
            bit_q    <= bit_d;
            last_q   <= last_d;
            word_q   <= word_d;
            wfill_q  <= wfill_d;
            wlast_q  <= wlast_d;
            wvalid_q <= wvalid_d;
        end
    end

`ifdef RUN_LENGTH_EXPANDER_BITCOUNT_EN
    logic [31:0] bit_count_q;

    // Accumulate the fill of every word the consumer takes.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bit_count_q <= '0;
        end else if (wvalid_q && bus.wordReady) begin
            bit_count_q <= bit_count_q + 32'(wfill_q);
        end
    end

    assign bitCount = bit_count_q;
`endif

    assign bus.tokReady  = tok_ready;
    assign bus.wordValid = wvalid_q;
    assign bus.word      = word_q;
    assign bus.wordFill  = wfill_q;
    assign bus.wordLast  = wlast_q;
    assign dbgState      = state_q;

endmodule

// File: tb/tb_run_length_expander.sv
// Directed bench for run_length_expander at WIDTH=8, LEN_WIDTH=8.
module tb_run_length_expander;
    import runLengthPkg::*;

    localparam int W  = 8;
    localparam int LW = 8;

    logic   clk;
    logic   resetN;
    state_t dbgState;
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;

    // Observed / expected words packed as {wordLast, wordFill[3:0], word[7:0]}.
    logic [12:0] obs_q[$];
    logic [12:0] exp_q[$];
    int          obs_cyc_q[$];

    run_length_expander_if #(.WIDTH(W), .LEN_WIDTH(LW)) bus ();

    run_length_expander #(.WIDTH(W), .LEN_WIDTH(LW)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .bus      (bus),
        .dbgState (dbgState)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every word taken by the consumer, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetN && bus.wordValid && bus.wordReady) begin
            obs_q.push_back({bus.wordLast, bus.wordFill, bus.word});
            obs_cyc_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_tok(input logic b, input int len, input logic last);
        int guard;
        logic [LW-1:0] len_v;
        guard = 0;
        len_v = LW'(len);
        bus.tokBit    = b;
        bus.tokLength = len_v;
        bus.tokLast   = last;
        bus.tokValid  = 1'b1;
        @(negedge clk);
        while (!bus.tokReady && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL tok_accept: tokReady=%0b after %0d cycles, required 1", bus.tokReady, guard);
        end
        @(posedge clk);
        #1;
        bus.tokValid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k;
        k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic clear_queues();
        obs_q.delete();
        exp_q.delete();
        obs_cyc_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetN = 1'b0;
        bus.tokValid = 1'b0;
        bus.tokBit = 1'b0;
        bus.tokLength = '0;
        bus.tokLast = 1'b0;
        bus.wordReady = 1'b1;
        #1;
        vectors++;
        if (bus.wordValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wordValid: got %0b required 0", bus.wordValid);
        end
        idle(2);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.tokReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tokReady: got %0b required 1", bus.tokReady);
        end
        vectors++;
        if ({bus.wordValid, bus.wordLast, bus.wordFill, bus.word} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_word: valid=%0b last=%0b fill=%0d word=%h required all 0",
                     bus.wordValid, bus.wordLast, bus.wordFill, bus.word);
        end
        vectors++;
        if (dbgState !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d required IDLE", dbgState);
        end
    endtask

    task automatic test_basic_pack();
        clear_queues();
        exp_q.push_back({1'b0, 4'd8, 8'b1110_0000});
        send_tok(1'b1, 3, 1'b0);
        send_tok(1'b0, 5, 1'b0);
        wait_words(1, 20);
        idle(4);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL basic_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL basic_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_long_run();
        clear_queues();
        exp_q.push_back({1'b0, 4'd8, 8'hFF});
        exp_q.push_back({1'b0, 4'd8, 8'hFF});
        exp_q.push_back({1'b1, 4'd8, 8'hF0});
        send_tok(1'b1, 20, 1'b0);
        send_tok(1'b0, 4, 1'b1);
        wait_words(3, 30);
        idle(4);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL long_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL long_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_cyc_q.size() >= 2) begin
            vectors++;
            if (obs_cyc_q[1] !== obs_cyc_q[0] + 1) begin
                miscompares++;
                $display("FAIL long_b2b: word1 cycle %0d required %0d", obs_cyc_q[1], obs_cyc_q[0] + 1);
            end
        end
    endtask

    task automatic test_flush_last();
        clear_queues();
        exp_q.push_back({1'b1, 4'd3, 8'b1110_0000});
        send_tok(1'b1, 3, 1'b1);
        wait_words(1, 20);
        idle(3);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL flush_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL flush_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (bus.tokReady !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_tokReady: got %0b required 1", bus.tokReady);
        end
    endtask

    task automatic test_backpressure();
        clear_queues();
        bus.wordReady = 1'b0;
        send_tok(1'b1, 24, 1'b0);
        idle(1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if ({bus.wordValid, bus.wordLast, bus.wordFill, bus.word} !== {1'b1, 1'b0, 4'd8, 8'hFF}) begin
                miscompares++;
                $display("FAIL hold_word[%0d]: valid=%0b last=%0b fill=%0d word=%h required 1/0/8/ff",
                         k, bus.wordValid, bus.wordLast, bus.wordFill, bus.word);
            end
            vectors++;
            if (bus.tokReady !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_tokReady[%0d]: got %0b required 0", k, bus.tokReady);
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 4'd8, 8'hFF});
        bus.wordReady = 1'b1;
        wait_words(3, 20);
        idle(4);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < obs_cyc_q.size(); i++) begin
            vectors++;
            if (obs_cyc_q[i] !== obs_cyc_q[i-1] + 1) begin
                miscompares++;
                $display("FAIL bp_bubble[%0d]: cycle %0d required %0d", i, obs_cyc_q[i], obs_cyc_q[i-1] + 1);
            end
        end
    endtask

    task automatic test_zero_length();
        clear_queues();
        exp_q.push_back({1'b1, 4'd0, 8'h00});
        send_tok(1'b1, 0, 1'b0);
        send_tok(1'b0, 0, 1'b1);
        wait_words(1, 20);
        idle(4);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL zero_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL zero_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        clear_queues();
        bus.wordReady = 1'b0;
        send_tok(1'b1, 18, 1'b0);
        idle(2);
        vectors++;
        if (dbgState !== RUN) begin
            miscompares++;
            $display("FAIL midrst_state: got %0d required RUN", dbgState);
        end
        resetN = 1'b0;
        #1;
        vectors++;
        if ({bus.wordValid, bus.wordLast, bus.wordFill, bus.word} !== 14'h0) begin
            miscompares++;
            $display("FAIL midrst_word: valid=%0b last=%0b fill=%0d word=%h required all 0",
                     bus.wordValid, bus.wordLast, bus.wordFill, bus.word);
        end
        vectors++;
        if (bus.tokReady !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_tokReady: got %0b required 1", bus.tokReady);
        end
        #2;
        resetN = 1'b1;
        bus.wordReady = 1'b1;
        idle(1);
        clear_queues();
        exp_q.push_back({1'b0, 4'd8, 8'hFF});
        send_tok(1'b1, 8, 1'b0);
        wait_words(1, 20);
        idle(5);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL midrst_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midrst_word[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_pack();
        test_long_run();
        test_flush_last();
        test_backpressure();
        test_zero_length();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
